// File: rtl/rv_lsu.sv
// MEM-stage load/store unit: turns decoder mem_read/mem_write into a req/gnt + rvalid
// data-memory transaction with byte enables, write-data replication, load formatting and timeout.
module rv_lsu #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        exc_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   localparam int unsigned CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          abort_q, abort_d;

   logic          acc, bad;
   logic [3:0]    be_n;
   logic [31:0]   wdata_n;
   logic [31:0]   shifted, load_fmt;

   // Request-side decode from the live pipeline inputs.
   always_comb begin
      acc = mem_read_i | mem_write_i;
      unique case (funct3_i)
         3'b000, 3'b100: bad = 1'b0;
         3'b001, 3'b101: bad = addr_i[0];
         3'b010:         bad = |addr_i[1:0];
         default:        bad = 1'b1;
      endcase
      unique case (funct3_i[1:0])
         2'b00: begin
            be_n    = 4'b0001 << addr_i[1:0];
            wdata_n = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_n    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{wdata_i[15:0]}};
         end
         default: begin
            be_n    = 4'b1111;
            wdata_n = wdata_i;
         end
      endcase
   end

   // Shift the addressed byte/half down to bit 0, then extend per the latched funct3.
   always_comb begin
      shifted = dmem_rdata_i >> {off_q, 3'b000};
      unique case (f3_q)
         3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_fmt = {24'b0, shifted[7:0]};
         3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_fmt = {16'b0, shifted[15:0]};
         default: load_fmt = dmem_rdata_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      abort_d = abort_q;
      exc_o   = 1'b0;
      stall_o = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (acc && bad) begin
               exc_o = 1'b1;
            end else if (acc) begin
               stall_o = 1'b1;
               we_d    = mem_write_i;
               addr_d  = {addr_i[31:2], 2'b00};
               be_d    = be_n;
               wdata_d = wdata_n;
               f3_d    = funct3_i;
               off_d   = addr_i[1:0];
               cnt_d   = '0;
               abort_d = 1'b0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            stall_o = 1'b1;
            if (dmem_gnt_i) begin
               cnt_d   = '0;
               state_d = we_q ? S_DONE : S_WAIT;
            end else if (cnt_q == CNT_LAST) begin
               exc_o   = 1'b1;
               abort_d = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            stall_o = 1'b1;
            if (dmem_rvalid_i) begin
               rdata_d = load_fmt;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               exc_o   = 1'b1;
               abort_d = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         rdata_q <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
         abort_q <= abort_d;
      end
   end

   assign dmem_req_o    = (state_q == S_REQ);
   assign dmem_we_o     = we_q;
   assign dmem_addr_o   = addr_q;
   assign dmem_be_o     = be_q;
   assign dmem_wdata_o  = wdata_q;
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = (state_q == S_DONE) && !we_q && !abort_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed self-checking bench for rv_lsu (TIMEOUT overridden to 8).
module tb_rv_lsu;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        mem_read_i, mem_write_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, rdata_valid_o, exc_o;
   logic [31:0] rdata_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   rv_lsu #(.TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .exc_o(exc_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Issue a load; gdly idle REQ cycles before gnt, rvalid rdly cycles after the gnt cycle.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input int unsigned gdly,
                          input int unsigned rdly, input logic [31:0] data,
                          input logic [3:0] exp_be, input logic [31:0] exp_rd, input string tag);
      mem_read_i = 1'b1; funct3_i = f3; addr_i = addr;
      #1;
      check({tag, " idle stall"}, 32'(stall_o), 32'd1);
      check({tag, " idle req"}, 32'(dmem_req_o), 32'd0);
      next_cycle();
      mem_read_i = 1'b0; addr_i = 32'hFFFF_FFFF;
      repeat (gdly) begin
         check({tag, " req held"}, 32'(dmem_req_o), 32'd1);
         next_cycle();
      end
      dmem_gnt_i = 1'b1;
      #1;
      check({tag, " req"}, 32'(dmem_req_o), 32'd1);
      check({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
      check({tag, " be"}, 32'(dmem_be_o), 32'(exp_be));
      check({tag, " we"}, 32'(dmem_we_o), 32'd0);
      next_cycle();
      dmem_gnt_i = 1'b0;
      repeat (rdly - 1) begin
         check({tag, " wait req"}, 32'(dmem_req_o), 32'd0);
         check({tag, " wait stall"}, 32'(stall_o), 32'd1);
         next_cycle();
      end
      dmem_rvalid_i = 1'b1; dmem_rdata_i = data;
      #1;
      check({tag, " rv stall"}, 32'(stall_o), 32'd1);
      next_cycle();
      dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h5555_5555;
      #1;
      check({tag, " done stall"}, 32'(stall_o), 32'd0);
      check({tag, " done valid"}, 32'(rdata_valid_o), 32'd1);
      check({tag, " rdata"}, rdata_o, exp_rd);
      next_cycle();
      check({tag, " valid pulse"}, 32'(rdata_valid_o), 32'd0);
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input int unsigned gdly, input logic both,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd, input string tag);
      mem_write_i = 1'b1; mem_read_i = both; funct3_i = f3; addr_i = addr; wdata_i = wd;
      #1;
      check({tag, " idle stall"}, 32'(stall_o), 32'd1);
      next_cycle();
      mem_write_i = 1'b0; mem_read_i = 1'b0; wdata_i = '0;
      repeat (gdly) next_cycle();
      dmem_gnt_i = 1'b1;
      #1;
      check({tag, " req"}, 32'(dmem_req_o), 32'd1);
      check({tag, " we"}, 32'(dmem_we_o), 32'd1);
      check({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
      check({tag, " be"}, 32'(dmem_be_o), 32'(exp_be));
      check({tag, " wdata"}, dmem_wdata_o, exp_wd);
      next_cycle();
      dmem_gnt_i = 1'b0;
      #1;
      check({tag, " done req"}, 32'(dmem_req_o), 32'd0);
      check({tag, " done stall"}, 32'(stall_o), 32'd0);
      check({tag, " done valid"}, 32'(rdata_valid_o), 32'd0);
      next_cycle();
   endtask

   task automatic do_bad(input logic [2:0] f3, input logic [31:0] addr, input string tag);
      mem_read_i = 1'b1; funct3_i = f3; addr_i = addr;
      #1;
      check({tag, " exc"}, 32'(exc_o), 32'd1);
      check({tag, " req"}, 32'(dmem_req_o), 32'd0);
      check({tag, " stall"}, 32'(stall_o), 32'd0);
      next_cycle();
      mem_read_i = 1'b0;
      #1;
      check({tag, " exc pulse"}, 32'(exc_o), 32'd0);
      check({tag, " no req"}, 32'(dmem_req_o), 32'd0);
   endtask

   initial begin
      rst_n_i = 1'b0;
      mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      #2;
      check("rst stall", 32'(stall_o), 32'd0);
      check("rst req", 32'(dmem_req_o), 32'd0);
      check("rst rdata", rdata_o, 32'd0);
      check("rst addr", dmem_addr_o, 32'd0);
      check("rst be", 32'(dmem_be_o), 32'd0);
      check("rst exc", 32'(exc_o), 32'd0);
      next_cycle();
      rst_n_i = 1'b1;
      next_cycle();

      do_load(3'b010, 32'h100, 2, 3, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "LW");
      do_load(3'b000, 32'h103, 0, 1, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80, "LB");
      do_load(3'b100, 32'h103, 1, 2, 32'h8012_3456, 4'b1000, 32'h0000_0080, "LBU");
      do_load(3'b001, 32'h102, 0, 1, 32'h8001_0000, 4'b1100, 32'hFFFF_8001, "LH");
      do_load(3'b101, 32'h102, 0, 1, 32'h8001_0000, 4'b1100, 32'h0000_8001, "LHU");
      do_load(3'b000, 32'h101, 0, 1, 32'h0000_7F00, 4'b0010, 32'h0000_007F, "LBpos");

      do_store(3'b000, 32'h101, 32'h0000_00AB, 0, 1'b0, 4'b0010, 32'hABAB_ABAB, "SB");
      do_store(3'b001, 32'h102, 32'h1234_CDEF, 1, 1'b0, 4'b1100, 32'hCDEF_CDEF, "SH");
      do_store(3'b010, 32'h204, 32'h0BAD_F00D, 0, 1'b1, 4'b1111, 32'h0BAD_F00D, "SWboth");

      do_bad(3'b010, 32'h102, "LWmis");
      do_bad(3'b011, 32'h100, "F011");
      do_bad(3'b001, 32'h101, "LHmis");
      do_bad(3'b110, 32'h100, "F110");

      // Timeout: gnt never arrives; abort in the 8th REQ cycle.
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h200;
      next_cycle();
      mem_read_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check("to req", 32'(dmem_req_o), 32'd1);
         check("to exc early", 32'(exc_o), 32'd0);
         next_cycle();
      end
      #1;
      check("to exc", 32'(exc_o), 32'd1);
      next_cycle();
      check("to req drop", 32'(dmem_req_o), 32'd0);
      check("to stall", 32'(stall_o), 32'd0);
      check("to valid", 32'(rdata_valid_o), 32'd0);
      check("to exc pulse", 32'(exc_o), 32'd0);
      next_cycle();

      // Reset while waiting for rvalid; stale rvalid afterwards must be ignored.
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h300;
      next_cycle();
      mem_read_i = 1'b0; dmem_gnt_i = 1'b1;
      next_cycle();
      dmem_gnt_i = 1'b0;
      #1;
      check("wr stall", 32'(stall_o), 32'd1);
      rst_n_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
      #1;
      check("wr rst stall", 32'(stall_o), 32'd0);
      check("wr rst req", 32'(dmem_req_o), 32'd0);
      check("wr rst rdata", rdata_o, 32'd0);
      check("wr rst addr", dmem_addr_o, 32'd0);
      next_cycle();
      rst_n_i = 1'b1;
      next_cycle();
      check("stale valid", 32'(rdata_valid_o), 32'd0);
      check("stale stall", 32'(stall_o), 32'd0);
      check("stale rdata", rdata_o, 32'd0);
      dmem_rvalid_i = 1'b0;
      next_cycle();
      do_load(3'b010, 32'h304, 1, 1, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, "LWpost");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
